// File: rtl/regfile_mp.sv
// Multi-port register file with pending-write scoreboard and a clear sweep.
// Optional same-cycle read forwarding is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int REG_COUNT = 16,
  parameter int REG_SIZE  = 8,
  parameter int NUM_RD    = 2,
  parameter int NUM_WR    = 2,
  localparam int PTR      = $clog2(REG_COUNT)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init_R0,
  input  logic [REG_SIZE-1:0]          init_R0_data,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*PTR-1:0]        wr_addr,
  input  logic [NUM_WR*REG_SIZE-1:0]   wr_data,
  input  logic [NUM_RD*PTR-1:0]        rd_addr,
  output logic [NUM_RD*REG_SIZE-1:0]   rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         issue_en,
  input  logic [PTR-1:0]               issue_dst,
  output logic [REG_COUNT-1:0]         busy,
  input  logic                         clear_req,
  output logic                         clear_busy,
  output logic                         ready,
  output logic                         dbg_clear_state
);

  // Handshake: wr_en / issue_en take effect only on an edge where ready is 1;
  // there is no backpressure beyond ready, the caller must hold off itself.

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t               state_q;
  logic [PTR-1:0]       cnt_q;
  logic [REG_SIZE-1:0]  r_q [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;

  logic [REG_COUNT-1:0] wr_hit;
  logic [REG_SIZE-1:0]  wr_val [REG_COUNT];
  logic                 accept;

  assign accept          = (state_q == IDLE);
  assign clear_busy      = (state_q == CLEAR);
  assign ready           = ~clear_busy;
  assign busy            = busy_q;
  assign dbg_clear_state = state_q;

  // Later ports overwrite earlier ones, so the highest-index match wins.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      wr_val[i] = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_en[k] && (wr_addr[k*PTR +: PTR] == PTR'(i))) begin
          wr_hit[i] = 1'b1;
          wr_val[i] = wr_data[k*REG_SIZE +: REG_SIZE];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == PTR'(REG_COUNT-1)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      for (int i = 0; i < REG_COUNT; i++) begin
        if (accept) begin
          if (wr_hit[i]) r_q[i] <= wr_val[i];
          // A new issue outranks a retiring write to the same register.
          if (issue_en && (issue_dst == PTR'(i))) busy_q[i] <= 1'b1;
          else if (wr_hit[i])                     busy_q[i] <= 1'b0;
        end else if (cnt_q == PTR'(i)) begin
          r_q[i]    <= '0;
          busy_q[i] <= 1'b0;
        end
      end

      if (init_R0) r_q[0] <= init_R0_data;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      logic [PTR-1:0] a;
      a = rd_addr[j*PTR +: PTR];
      rd_data[j*REG_SIZE +: REG_SIZE] = r_q[a];
      rd_busy[j]                      = busy_q[a];
`ifdef REGFILE_BYPASS_EN
      if (accept) begin
        if (wr_hit[a]) begin
          rd_data[j*REG_SIZE +: REG_SIZE] = wr_val[a];
          rd_busy[j] = issue_en && (issue_dst == a);
        end
        if (init_R0 && (a == '0)) rd_data[j*REG_SIZE +: REG_SIZE] = init_R0_data;
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default 16 x 8, 2R/2W).
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_R0;
  logic [7:0]  init_R0_data;
  logic [1:0]  wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [1:0]  rd_busy;
  logic        issue_en;
  logic [3:0]  issue_dst;
  logic [15:0] busy;
  logic        clear_req;
  logic        clear_busy;
  logic        ready;
  logic        dbg_clear_state;

  int n_checks = 0;
  int n_errors = 0;

  regfile_mp dut (
    .clk(clk), .reset(reset), .init_R0(init_R0), .init_R0_data(init_R0_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .issue_en(issue_en), .issue_dst(issue_dst), .busy(busy),
    .clear_req(clear_req), .clear_busy(clear_busy), .ready(ready),
    .dbg_clear_state(dbg_clear_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    init_R0 = 1'b0; init_R0_data = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_dst = '0; clear_req = 1'b0;
  endtask

  task automatic write2(input logic [1:0] en, input logic [3:0] a0, input logic [7:0] d0,
                        input logic [3:0] a1, input logic [7:0] d1);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
    tick();
    wr_en = '0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      rd_addr = {4'(15 - a), 4'(a)};
      #1;
      check({tag, "_rd"}, {rd_data, 14'b0, rd_busy}, 32'h0);
    end
  endtask

  int  cyc;
  logic rdy_ok;

  initial begin
    idle_inputs();
    rd_addr = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_busy", busy, 16'h0000);
    check("rst_ready", ready, 1'b1);
    check("rst_clear_busy", clear_busy, 1'b0);
    check_all_zero("rst");

    // Two ports to the same register: port 1 wins
    write2(2'b11, 4'd5, 8'hAA, 4'd5, 8'h55);
    rd_addr = {4'd6, 4'd5}; #1;
    check("same_addr_win", rd_data[7:0], 8'h55);
    check("neighbour_untouched", rd_data[15:8], 8'h00);

    // Two ports to different registers
    write2(2'b11, 4'd7, 8'h11, 4'd8, 8'h22);
    rd_addr = {4'd8, 4'd7}; #1;
    check("dual_write", rd_data, 16'h2211);

    // Scoreboard set / hold on collision / clear
    issue_en = 1'b1; issue_dst = 4'd3;
    tick();
    issue_en = 1'b0;
    rd_addr = {4'd3, 4'd5}; #1;
    check("issue_busy", busy, 16'h0008);
    check("issue_rd_busy", rd_busy, 2'b10);
    issue_en = 1'b1; issue_dst = 4'd3;
    write2(2'b01, 4'd3, 8'h12, 4'd0, 8'h00);
    issue_en = 1'b0; #1;
    check("collide_busy", busy, 16'h0008);
    check("collide_data", rd_data[15:8], 8'h12);
    write2(2'b10, 4'd0, 8'h00, 4'd3, 8'h34);
    #1;
    check("retire_busy", busy, 16'h0000);
    check("retire_data", rd_data[15:8], 8'h34);

    // init_R0 beats a write port, and leaves busy[0] alone
    init_R0 = 1'b1; init_R0_data = 8'h7F;
    write2(2'b01, 4'd0, 8'h01, 4'd0, 8'h00);
    init_R0 = 1'b0;
    rd_addr = {4'd5, 4'd0}; #1;
    check("init_r0_wins", rd_data[7:0], 8'h7F);
    issue_en = 1'b1; issue_dst = 4'd0;
    tick();
    issue_en = 1'b0;
    init_R0 = 1'b1; init_R0_data = 8'h3C;
    tick();
    init_R0 = 1'b0; #1;
    check("init_r0_busy_kept", busy, 16'h0001);
    check("init_r0_value", rd_data[7:0], 8'h3C);

    // Fill r1..r15 then sweep
    for (int i = 1; i < 16; i += 2)
      write2(i < 15 ? 2'b11 : 2'b01, 4'(i), 8'(8'h10 + i), 4'(i + 1), 8'(8'h10 + i + 1));
    rd_addr = {4'd15, 4'd9}; #1;
    check("fill_data", rd_data, 16'h1F19);

    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    cyc = 0; rdy_ok = 1'b1;
    for (int t = 0; t < 40; t++) begin
      if (!clear_busy) break;
      cyc++;
      if (ready !== ~clear_busy) rdy_ok = 1'b0;
      wr_en = 2'b11; wr_addr = {4'd2, 4'd4}; wr_data = 16'hFFFF;
      issue_en = 1'b1; issue_dst = 4'd4;
      clear_req = (cyc == 5);
      tick();
      wr_en = '0; issue_en = 1'b0; clear_req = 1'b0;
    end
    check("sweep_len", cyc, 16);
    check("sweep_ready", rdy_ok, 1'b1);
    check("sweep_busy", busy, 16'h0000);
    check("sweep_ready_after", ready, 1'b1);
    check_all_zero("sweep");

    // Reset in the middle of a sweep
    for (int i = 1; i < 16; i += 2)
      write2(i < 15 ? 2'b11 : 2'b01, 4'(i), 8'(8'hA0 + i), 4'(i + 1), 8'(8'hA0 + i + 1));
    issue_en = 1'b1; issue_dst = 4'd12;
    tick();
    issue_en = 1'b0;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int t = 1; t < 8; t++) tick();
    check("abort_in_sweep", clear_busy, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_idle", clear_busy, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_busy", busy, 16'h0000);
    check_all_zero("abort");

    // Same-cycle read of a write
    wr_en = 2'b01; wr_addr = {4'd0, 4'd9}; wr_data = 16'h00C3;
    rd_addr = {4'd0, 4'd9}; #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_read", rd_data[7:0], 8'hC3);
`else
    check("same_cycle_read", rd_data[7:0], 8'h00);
`endif
    tick();
    wr_en = '0; #1;
    check("next_cycle_read", rd_data[7:0], 8'hC3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the core pipeline, successor to the single-writeback file. It provides NUM_RD combinational read ports for decode and NUM_WR writeback ports, plus a per-register pending-write scoreboard for hazard detection. Software can request a multi-cycle clear sequence. R0 keeps its dedicated init load path. It sits between decode (reads, issue) and writeback (writes).

## Interface
- REG_COUNT, 16, number of registers, power of two ≥ 2
- REG_SIZE, 8, register width in bits
- NUM_RD, 2, read ports
- NUM_WR, 2, write ports
- PTR = $clog2(REG_COUNT), derived localparam
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- init_R0  in  1  load init_R0_data into R0
- init_R0_data  in  REG_SIZE  R0 init value
- wr_en  in  NUM_WR  per-port write enable
- wr_addr  in  NUM_WR*PTR  write addresses, port k at [k*PTR +: PTR]
- wr_data  in  NUM_WR*REG_SIZE  write data, port k at [k*REG_SIZE +: REG_SIZE]
- rd_addr  in  NUM_RD*PTR  read addresses
- rd_data  out  NUM_RD*REG_SIZE  read data
- rd_busy  out  NUM_RD  scoreboard bit of each read address
- issue_en  in  1  mark issue_dst pending
- issue_dst  in  PTR  destination being issued
- busy  out  REG_COUNT  scoreboard vector
- clear_req  in  1  start clear sweep (pulse)
- clear_busy  out  1  sweep in progress
- ready  out  1  ~clear_busy; writes/issue accepted

## Operation
- Storage: REG_COUNT × REG_SIZE flops. rd_data[j] = r[rd_addr[j]], combinational.
- Write: on posedge, for each register, the highest-index port k with wr_en[k] and a matching wr_addr wins and is written.
- R0: init_R0 overrides all write ports for R0. It does not touch busy[0].
- Scoreboard:
  - busy[i] is set by issue_en with issue_dst==i.
  - busy[i] is cleared by any accepted write to i.
  - Issue and write to the same register in the same cycle: busy stays 1, because the new pending write takes precedence.
- rd_busy[j] = busy[rd_addr[j]].
- Clear FSM, states IDLE and CLEAR, with a PTR-bit counter cnt:
  - IDLE→CLEAR on clear_req; cnt←0.
  - In CLEAR, each cycle writes r[cnt]←0 and busy[cnt]←0, then cnt++.
  - CLEAR→IDLE after the cycle in which cnt==REG_COUNT-1 (wrap to 0).
  - clear_req while in CLEAR is ignored.
- During CLEAR:
  - wr_en and issue_en are ignored and have no effect.
  - init_R0 is still honoured, and wins over the sweep zeroing R0.
  - Reads remain live.
- Out-of-range addresses are impossible (REG_COUNT = 2^PTR).

## Timing
- Reset:
  - All r = 0, busy = 0, FSM = IDLE, cnt = 0.
  - Hence rd_data = 0, rd_busy = 0, clear_busy = 0, ready = 1 from the first cycle after reset.
- Reset asserted mid-sweep aborts to IDLE with every register zeroed.
- Read latency 0 (combinational). A write at edge t is visible on rd_data after edge t (without bypass).
- Scoreboard update: visible on busy/rd_busy one cycle after issue_en/write.
- Clear:
  - clear_req sampled at edge t makes clear_busy = 1 from t for exactly REG_COUNT cycles.
  - ready is low for the same window.

## Configuration
- REGFILE_BYPASS_EN defined: same-cycle forwarding.
  - If any wr_en[k] matches rd_addr[j], rd_data[j] returns the winning wr_data (highest k), and rd_busy[j] = 0 unless issue_en also targets that address.
  - init_R0 forwards to reads of R0 with the highest priority.
  - Bypass is inactive during CLEAR.
- Undefined: reads return stored values only. Writes are visible the next cycle.

## Test plan
- Reset, then read all 16 addresses → rd_data = 0, busy = 16'h0000, ready = 1.
- wr_en=2'b11, both ports addr 5, data 8'hAA (port0) / 8'h55 (port1) → next cycle r5 reads 8'h55.
- issue_en dst 3 → busy[3]=1 next cycle. Write r3=8'h12 while issue_en dst 3 → busy[3] stays 1, r3=8'h12. Write again without issue → busy[3]=0.
- init_R0 with 8'h7F plus wr_en port0 addr 0 data 8'h01 → R0 = 8'h7F.
- Load r1..r15 with nonzero values, pulse clear_req:
  - clear_busy high exactly 16 cycles, and writes during the window have no effect.
  - Afterwards all registers = 0 and busy = 0.
  - Repeat with reset at cycle 8 of the sweep → IDLE, all 0.
- With REGFILE_BYPASS_EN: write r9=8'hC3 while rd_addr0=9 → rd_data0=8'hC3 in the same cycle. Without the macro, the same-cycle read returns the old value (0) and 8'hC3 next cycle.
